// File: rtl/atri_pps_timebase.sv
// PPS timebase for the ATRI PHY: validates the external PPS, measures the
// clk_i period between accepted pulses and tracks lock plus a sub-second us count.
module atri_pps_timebase #(
  parameter int unsigned PPS_HOLDOFF_MS = 900,
  parameter int unsigned PPS_TIMEOUT_MS = 1100,
  parameter int unsigned NBITS_CYC      = 32,
  parameter int unsigned NBITS_US       = 20,
  parameter int unsigned NBITS_MS       = 11
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 pps_i,
  input  logic                 MHz_CE_i,
  input  logic                 KHz_CE_i,
  output logic                 pps_flag_o,
  output logic [31:0]          pps_count_o,
  output logic [NBITS_CYC-1:0] cycle_count_o,
  output logic                 cycle_valid_o,
  output logic [NBITS_US-1:0]  us_count_o,
  output logic                 pps_locked_o
);

  typedef enum logic [1:0] {
    ST_NOSYNC  = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_ARMED   = 2'd2
  } state_e;

  localparam logic [NBITS_MS-1:0] HOLDOFF_MS = NBITS_MS'(PPS_HOLDOFF_MS);
  localparam logic [NBITS_MS-1:0] TIMEOUT_MS = NBITS_MS'(PPS_TIMEOUT_MS);

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, sync3_q;
  logic [1:0]           settle_q;
  logic                 rise;
  logic                 accept;
  logic                 accept_q;
  logic                 pps_flag_q;
  logic [NBITS_CYC-1:0] cyc_q, cyc_d, cyc_inc;
  logic [NBITS_MS-1:0]  ms_q, ms_d;
  logic [NBITS_US-1:0]  us_q, us_d;
  logic [31:0]          pps_count_q, pps_count_d;
  logic [NBITS_CYC-1:0] cycle_count_q, cycle_count_d;
  logic                 cycle_valid_q, cycle_valid_d;

  // The synchronizer refilling after reset with pps_i already high would look
  // like a fresh edge; edges are only qualified once the pipeline has settled.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value;
      // blocking here would collapse the three-stage pipeline into one stage.
      sync1_q <= pps_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  assign rise    = sync2_q & ~sync3_q & (settle_q == 2'd3);
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + NBITS_CYC'(1);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    accept        = 1'b0;
    cyc_d         = cyc_inc;
    ms_d          = ms_q;
    us_d          = us_q;
    pps_count_d   = pps_count_q;
    cycle_count_d = cycle_count_q;
    cycle_valid_d = cycle_valid_q;

    if (KHz_CE_i && !(&ms_q)) ms_d = ms_q + NBITS_MS'(1);
    if (MHz_CE_i && !(&us_q)) us_d = us_q + NBITS_US'(1);

    case (state_q)
      ST_NOSYNC: begin
        if (rise) accept = 1'b1;
      end
      ST_HOLDOFF: begin
        // Rises here are discarded, even on the cycle holdoff expires.
        if (ms_q >= TIMEOUT_MS)      state_d = ST_NOSYNC;
        else if (ms_q >= HOLDOFF_MS) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (rise)                    accept  = 1'b1;
        else if (ms_q >= TIMEOUT_MS) state_d = ST_NOSYNC;
      end
      default: state_d = ST_NOSYNC;
    endcase

    if (state_q != ST_NOSYNC && state_d == ST_NOSYNC) cycle_valid_d = 1'b0;

    // Accept overrides any same-cycle tick or timeout.
    if (accept) begin
      state_d     = ST_HOLDOFF;
      cyc_d       = '0;
      ms_d        = '0;
      us_d        = '0;
      pps_count_d = pps_count_q + 32'd1;
      if (state_q == ST_ARMED) begin
        cycle_count_d = cyc_inc;
        cycle_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_NOSYNC;
      cyc_q         <= '0;
      ms_q          <= '0;
      us_q          <= '0;
      pps_count_q   <= '0;
      cycle_count_q <= '0;
      cycle_valid_q <= 1'b0;
      accept_q      <= 1'b0;
      pps_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      ms_q          <= ms_d;
      us_q          <= us_d;
      pps_count_q   <= pps_count_d;
      cycle_count_q <= cycle_count_d;
      cycle_valid_q <= cycle_valid_d;
      accept_q      <= accept;
      pps_flag_q    <= accept_q;
    end
  end

  // The flag trails the counter clear by one edge, landing on the 4th edge
  // counted from the one that first samples pps_i high.
  assign pps_flag_o    = pps_flag_q;
  assign pps_count_o   = pps_count_q;
  assign cycle_count_o = cycle_count_q;
  assign cycle_valid_o = cycle_valid_q;
  assign us_count_o    = us_q;
  assign pps_locked_o  = (state_q != ST_NOSYNC);

endmodule

// File: tb/tb_atri_pps_timebase.sv
// Directed bench for atri_pps_timebase, with holdoff/timeout scaled so that one
// ms is 100 clk cycles and one us is 10 clk cycles.
module tb_atri_pps_timebase;

  localparam int HOLD_MS = 9;
  localparam int TOUT_MS = 12;
  localparam int NCYC    = 10;
  localparam int NUS     = 20;
  localparam int NMS     = 11;
  localparam int MHZ_DIV = 10;
  localparam int KHZ_DIV = 100;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            pps = 1'b0;
  logic            mhz_ce = 1'b0;
  logic            khz_ce = 1'b0;
  logic            pps_flag;
  logic [31:0]     pps_count;
  logic [NCYC-1:0] cycle_count;
  logic            cycle_valid;
  logic [NUS-1:0]  us_count;
  logic            pps_locked;

  int vectors     = 0;
  int miscompares = 0;
  int n           = 0;
  int flag_cnt    = 0;
  int flag_at     = -1;
  bit mhz_en      = 1'b0;
  bit khz_en      = 1'b0;

  atri_pps_timebase #(
    .PPS_HOLDOFF_MS(HOLD_MS),
    .PPS_TIMEOUT_MS(TOUT_MS),
    .NBITS_CYC     (NCYC),
    .NBITS_US      (NUS),
    .NBITS_MS      (NMS)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .pps_i        (pps),
    .MHz_CE_i     (mhz_ce),
    .KHz_CE_i     (khz_ce),
    .pps_flag_o   (pps_flag),
    .pps_count_o  (pps_count),
    .cycle_count_o(cycle_count),
    .cycle_valid_o(cycle_valid),
    .us_count_o   (us_count),
    .pps_locked_o (pps_locked)
  );

  always #5 clk = ~clk;

  // One PPS scenario: rise `gap` cycles after the last accepted rise, held
  // high for hi_len cycles, then the expected post-event outputs.
  typedef struct {
    int gap;
    int hi_len;
    bit accept;
    int exp_count;
    int exp_cycle;
    bit exp_valid;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, n);
    end
  endtask

  task automatic check_range(input string name, input logic [63:0] got,
                             input logic [63:0] lo, input logic [63:0] hi);
    vectors++;
    if ((^got === 1'bx) || got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, got, lo, hi, n);
    end
  endtask

  // Advance one clock: sample just after the edge, then drive the next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
    if (pps_flag === 1'b1) begin
      flag_cnt++;
      flag_at = n;
    end
    mhz_ce = mhz_en && (n % MHZ_DIV == 0);
    khz_ce = khz_en && (n % KHZ_DIV == 0);
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step();
  endtask

  task automatic step_until(input int t);
    while (n < t) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flag"},   64'(pps_flag),    64'd0);
    check({tag, "_count"},  64'(pps_count),   64'd0);
    check({tag, "_cycle"},  64'(cycle_count), 64'd0);
    check({tag, "_valid"},  64'(cycle_valid), 64'd0);
    check({tag, "_us"},     64'(us_count),    64'd0);
    check({tag, "_locked"}, 64'(pps_locked),  64'd0);
  endtask

  initial begin
    vec_t vecs[7];
    int   k_acc;
    int   target;
    int   flags_before;
    int   waited;
    int   us_snap;

    vecs[0] = '{gap: 1000, hi_len: 5, accept: 1'b1, exp_count: 2, exp_cycle: 1000, exp_valid: 1'b1};
    vecs[1] = '{gap:  500, hi_len: 3, accept: 1'b0, exp_count: 2, exp_cycle: 1000, exp_valid: 1'b1};
    vecs[2] = '{gap: 1000, hi_len: 5, accept: 1'b1, exp_count: 3, exp_cycle: 1000, exp_valid: 1'b1};
    vecs[3] = '{gap:  980, hi_len: 5, accept: 1'b1, exp_count: 4, exp_cycle:  980, exp_valid: 1'b1};
    vecs[4] = '{gap: 1050, hi_len: 5, accept: 1'b1, exp_count: 5, exp_cycle: 1023, exp_valid: 1'b1};
    vecs[5] = '{gap:  800, hi_len: 5, accept: 1'b0, exp_count: 5, exp_cycle: 1023, exp_valid: 1'b1};
    vecs[6] = '{gap: 1000, hi_len: 5, accept: 1'b1, exp_count: 6, exp_cycle: 1000, exp_valid: 1'b1};

    // Reset state, then idle with only the kHz strobe running past timeout.
    run(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    khz_en  = 1'b1;
    run(1300);
    check_all_zero("idle");
    check("idle_flags", 64'(flag_cnt), 64'd0);

    // First PPS from NOSYNC: flag latency and single-cycle width.
    mhz_en = 1'b1;
    target = n + 5;
    step_until(target);
    pps = 1'b1;
    run(20);
    pps = 1'b0;
    step_until(target + 30);
    check("first_flag_cnt", 64'(flag_cnt), 64'd1);
    check("first_flag_at",  64'(flag_at),  64'(target + 4));
    check("first_count",    64'(pps_count),   64'd1);
    check("first_locked",   64'(pps_locked),  64'd1);
    check("first_valid",    64'(cycle_valid), 64'd0);
    check("first_cycle",    64'(cycle_count), 64'd0);
    k_acc = target;

    foreach (vecs[i]) begin
      target = k_acc + vecs[i].gap;
      step_until(target);
      check_range($sformatf("v%0d_us_before", i), 64'(us_count),
                  64'((vecs[i].gap - 3) / MHZ_DIV), 64'((vecs[i].gap - 3) / MHZ_DIV + 1));
      flags_before = flag_cnt;
      pps = 1'b1;
      run(vecs[i].hi_len);
      pps = 1'b0;
      run(8);
      check($sformatf("v%0d_flags", i), 64'(flag_cnt - flags_before), 64'(vecs[i].accept));
      if (vecs[i].accept) begin
        check($sformatf("v%0d_flag_at", i), 64'(flag_at), 64'(target + 4));
        check_range($sformatf("v%0d_us_after", i), 64'(us_count), 64'd0, 64'd2);
        k_acc = target;
      end
      check($sformatf("v%0d_count", i),  64'(pps_count),   64'(vecs[i].exp_count));
      check($sformatf("v%0d_cycle", i),  64'(cycle_count), 64'(vecs[i].exp_cycle));
      check($sformatf("v%0d_valid", i),  64'(cycle_valid), 64'(vecs[i].exp_valid));
      check($sformatf("v%0d_locked", i), 64'(pps_locked),  64'd1);
    end

    // PPS stops: lock drops at the timeout, measurement retained.
    waited = 0;
    while (pps_locked === 1'b1 && waited < 2000) begin
      step();
      waited++;
    end
    check_range("timeout_point", 64'(n - (k_acc + 3)), 64'd1100, 64'd1202);
    check("timeout_valid",  64'(cycle_valid), 64'd0);
    check("timeout_cycle",  64'(cycle_count), 64'd1000);
    check("timeout_count",  64'(pps_count),   64'd6);
    us_snap = int'(us_count);
    run(25);
    check_range("timeout_us_runs", 64'(us_count), 64'(us_snap + 2), 64'(us_snap + 3));

    // Re-acquire from NOSYNC: no valid measurement until a second PPS.
    target = n + 10;
    step_until(target);
    pps = 1'b1;
    run(5);
    pps = 1'b0;
    run(8);
    check("reacq_flag_at", 64'(flag_at),     64'(target + 4));
    check("reacq_count",   64'(pps_count),   64'd7);
    check("reacq_locked",  64'(pps_locked),  64'd1);
    check("reacq_valid",   64'(cycle_valid), 64'd0);
    check("reacq_cycle",   64'(cycle_count), 64'd1000);
    k_acc  = target;
    target = k_acc + 1000;
    step_until(target);
    pps = 1'b1;
    run(5);
    pps = 1'b0;
    run(8);
    check("relock_count", 64'(pps_count),   64'd8);
    check("relock_cycle", 64'(cycle_count), 64'd1000);
    check("relock_valid", 64'(cycle_valid), 64'd1);

    // Asynchronous reset mid-second with pps_i high, released while still high.
    run(300);
    pps = 1'b1;
    run(2);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    run(3);
    reset_n      = 1'b1;
    flags_before = flag_cnt;
    run(20);
    check("held_high_flags",  64'(flag_cnt - flags_before), 64'd0);
    check("held_high_count",  64'(pps_count),  64'd0);
    check("held_high_locked", 64'(pps_locked), 64'd0);
    pps = 1'b0;
    run(5);
    target = n;
    pps = 1'b1;
    run(10);
    check("post_rst_flag_at", 64'(flag_at),    64'(target + 4));
    check("post_rst_count",   64'(pps_count),  64'd1);
    check("post_rst_locked",  64'(pps_locked), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/atri_pps_timebase.md
Name: atri_pps_timebase

Overview:
- Consumes the MHz/KHz clock-enable strobes from the ATRI slow clock generator, together with the external PPS input.
- Produces a validated PPS pulse, a PPS-to-PPS clock-cycle measurement, a microsecond sub-second counter and a lock/timeout status.
- Sits in the ATRI PHY between the slow clock generator and the event timestamping/housekeeping logic.

Parameters:
- PPS_HOLDOFF_MS, 900: ms after an accepted PPS during which further PPS edges are ignored.
- PPS_TIMEOUT_MS, 1100: ms without an accepted PPS before lock is dropped.
- NBITS_CYC, 32: width of the cycle counter and cycle measurement.
- NBITS_US, 20: width of the microsecond counter.
- NBITS_MS, 11: width of the internal ms counter; must hold PPS_TIMEOUT_MS.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- pps_i  in  1  raw PPS, asynchronous to clk_i.
- MHz_CE_i  in  1  one-cycle 1 MHz clock enable.
- KHz_CE_i  in  1  one-cycle 1 kHz clock enable.
- pps_flag_o  out  1  one-cycle pulse per accepted PPS.
- pps_count_o  out  32  number of accepted PPS since reset; wraps.
- cycle_count_o  out  NBITS_CYC  clk_i cycles between the last two accepted PPS.
- cycle_valid_o  out  1  cycle_count_o holds a measurement made while locked.
- us_count_o  out  NBITS_US  MHz_CE ticks since the last accepted PPS.
- pps_locked_o  out  1  PPS present and within timeout.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - All outputs 0; state NOSYNC.
  - All internal counters and synchronizer flops 0.
  - Reset asserted mid-operation returns the block to this condition immediately; there is no pending-edge memory.
- Input path:
  - pps_i is passed through a 2-flop synchronizer plus a third flop for edge detection.
  - rise = sync2 & ~sync3.
  - A level held high never re-triggers.
- Latency: pps_flag_o is high for exactly one cycle, 4 clk_i edges after the first edge that samples pps_i high (3 edges to rise, plus 1 registered output).
- Internal counters:
  - cyc: increments every cycle; saturates at all-ones.
  - ms: increments on KHz_CE_i; saturates at all-ones.
  - us_count_o: increments on MHz_CE_i; saturates at all-ones.
- Accept rule: rise is accepted when the state is NOSYNC or ARMED. A rise in HOLDOFF is discarded with no effect on any counter.
- On accept (same cycle, all registered):
  - cyc <= 0; ms <= 0; us_count_o <= 0.
  - pps_count_o += 1.
  - pps_flag_o <= 1 on the next edge.
  - If the state was ARMED: cycle_count_o <= cyc+1 and cycle_valid_o <= 1.
  - If the state was NOSYNC: cycle_count_o is unchanged and cycle_valid_o stays 0.
  - Next state is HOLDOFF.
- State machine:
  - NOSYNC -> HOLDOFF on accept.
  - HOLDOFF -> ARMED when ms >= PPS_HOLDOFF_MS.
  - HOLDOFF or ARMED -> NOSYNC when ms >= PPS_TIMEOUT_MS with no accept in that cycle.
  - ARMED -> HOLDOFF on accept.
- Timeout side effects:
  - pps_locked_o <= 0 and cycle_valid_o <= 0.
  - cycle_count_o, us_count_o and pps_count_o keep their values; us_count_o keeps counting.
- pps_locked_o is 1 exactly while the state is HOLDOFF or ARMED.
- Simultaneous events:
  - Accept with MHz_CE_i or KHz_CE_i in the same cycle: the counter clears to 0; the tick is dropped.
  - Accept in the same cycle the timeout condition is reached: accept wins and the state goes to HOLDOFF.
  - Reaching PPS_HOLDOFF_MS and a rise in the same cycle: the rise is evaluated against the current state (HOLDOFF), so it is discarded.
- Width and arithmetic:
  - All counters are unsigned.
  - cycle_count_o = cyc+1 computed at NBITS_CYC. If cyc is saturated, cycle_count_o = all-ones; it does not wrap to 0.

Test Plan:
1. Reset release, no PPS, KHz_CE_i pulsing -> all outputs stay 0 and the state stays NOSYNC. pps_locked_o is 0 even past 1100 ms.
2. pps_i rises at cycle 100 -> pps_flag_o high for one cycle only, on the 4th edge after sampling. pps_count_o=1, pps_locked_o=1, cycle_valid_o=0.
3. Second PPS exactly 48,000,000 cycles after the first, with MHz_CE_i every 48 cycles and KHz_CE_i every 48,000 -> cycle_count_o=48000000 and cycle_valid_o=1. us_count_o reads 999999 or 1000000 just before the edge and returns to 0 after.
4. Glitch PPS 500 ms after an accepted PPS -> no flag; pps_count_o, us_count_o and ms unchanged. A true PPS at 1000 ms is accepted with the correct cycle_count_o.
5. Stop PPS after lock -> at ms=1100, pps_locked_o=0 and cycle_valid_o=0, while cycle_count_o is retained. The next PPS is accepted from NOSYNC, with cycle_valid_o still 0 until a further PPS.
6. Assert reset_n_i=0 mid-second with pps_i held high -> outputs clear asynchronously. After release with pps_i still high there is no flag until pps_i falls and rises again.
